button_debounce: RTL and testbench



---
 rtl/button_debounce.sv | 207 ++++++++++++++++++++
 tb/tb_button_debounce.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce
// Purpose  : Push-button conditioner. Synchronises a raw, bouncing pin into
//            the clock domain, debounces it with one shared cycle counter and
//            a four-state FSM, and produces a clean pressed level, one-cycle
//            press / release / long-press pulses and a wrapping press count.
// Revision : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 250000,   // stable cycles before a press/release is accepted (>= 1)
    parameter int unsigned LONG_CYC     = 25000000, // cycles in HELD before long_o fires; 0 disables it
    parameter bit          ACTIVE_LOW   = 1'b1      // 1: pin reads 0 when pressed
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       btn_i,
    output logic       pressed_o,
    output logic       press_o,
    output logic       release_o,
    output logic       long_o,
    output logic [7:0] count_o
);

    // ------------------------------------------------------------------------
    // Counter sizing: one counter serves both the debounce windows and the
    // long-press timer, so it must reach max(DEBOUNCE_CYC, LONG_CYC) - 1.
    // ------------------------------------------------------------------------
    localparam int unsigned CNT_MAX = (DEBOUNCE_CYC > LONG_CYC) ? DEBOUNCE_CYC : LONG_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam bit               LONG_EN   = (LONG_CYC != 0);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = LONG_EN ? CNT_W'(LONG_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Pin level when the button is not pressed; the synchroniser resets to it
    // so that leaving reset never looks like an edge.
    localparam logic [1:0]       SYNC_RST  = {2{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_HELD         = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_e;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [1:0]       sync_q;
    logic [1:0]       sync_d;
    logic             lvl;

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             long_fired_q;
    logic             long_fired_d;

    logic             pressed_q;
    logic             pressed_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;
    logic             long_q;
    logic             long_d;
    logic [7:0]       count_q;
    logic [7:0]       count_d;

    // ------------------------------------------------------------------------
    // Synchroniser: stage 0 samples the asynchronous pin, stage 1 is the only
    // stage the FSM ever looks at.
    // ------------------------------------------------------------------------

    // Shift the pin into the two-flop synchroniser chain.
    always_comb begin
        sync_d = {sync_q[0], btn_i};
    end

    // Synchroniser flops, reset to the released pin level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= SYNC_RST;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Normalised level: 1 means the button is pressed regardless of polarity.
    assign lvl = sync_q[1] ^ ACTIVE_LOW;

    // Saturating increment; the counter must never wrap back into a window.
    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : (cnt_q + CNT_ONE);

    // ------------------------------------------------------------------------
    // Debounce FSM next-state and registered-output logic
    // ------------------------------------------------------------------------

    // Compute next state, counter, long-press latch and output registers.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        long_fired_d = long_fired_q;
        pressed_d    = pressed_q;
        press_d      = 1'b0;
        release_d    = 1'b0;
        long_d       = 1'b0;
        count_d      = count_q;

        case (state_q)
            S_IDLE: begin
                if (lvl) begin
                    state_d = S_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end

            S_PRESS_WAIT: begin
                if (!lvl) begin
                    // Pressed level did not survive the window: a glitch.
                    state_d = S_IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = S_HELD;
                    cnt_d     = '0;
                    pressed_d = 1'b1;
                    press_d   = 1'b1;
                    count_d   = count_q + 8'd1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_HELD: begin
                if (!lvl) begin
                    state_d = S_RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (LONG_EN && !long_fired_q && (cnt_q == LONG_LAST)) begin
                    // Fire once per press; the counter then parks here.
                    long_d       = 1'b1;
                    long_fired_d = 1'b1;
                end else if (!long_fired_q) begin
                    cnt_d = cnt_inc;
                end
            end

            S_RELEASE_WAIT: begin
                if (lvl) begin
                    // Release bounce: still the same press, keep long_fired.
                    state_d = S_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d      = S_IDLE;
                    cnt_d        = '0;
                    pressed_d    = 1'b0;
                    release_d    = 1'b1;
                    long_fired_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state, counter and all registered outputs; reset clears everything.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            long_fired_q <= 1'b0;
            pressed_q    <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            long_q       <= 1'b0;
            count_q      <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            long_fired_q <= long_fired_d;
            pressed_q    <= pressed_d;
            press_q      <= press_d;
            release_q    <= release_d;
            long_q       <= long_d;
            count_q      <= count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign pressed_o = pressed_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
    assign count_o   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_debounce
// Purpose  : Directed, table-driven bench for button_debounce with
//            DEBOUNCE_CYC=4, LONG_CYC=10, ACTIVE_LOW=1, plus a second instance
//            with LONG_CYC=0 that must never raise long_o.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_debounce;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn   = 1'b1;

    logic       pressed, press, rel, lng;
    logic [7:0] cnt;
    logic       pressed_n, press_n, rel_n, lng_n;
    logic [7:0] cnt_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    button_debounce #(
        .DEBOUNCE_CYC (4),
        .LONG_CYC     (10),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .btn_i     (btn),
        .pressed_o (pressed),
        .press_o   (press),
        .release_o (rel),
        .long_o    (lng),
        .count_o   (cnt)
    );

    button_debounce #(
        .DEBOUNCE_CYC (4),
        .LONG_CYC     (0),
        .ACTIVE_LOW   (1'b1)
    ) dut_nl (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .btn_i     (btn),
        .pressed_o (pressed_n),
        .press_o   (press_n),
        .release_o (rel_n),
        .long_o    (lng_n),
        .count_o   (cnt_n)
    );

    // One row = pin value applied before a rising edge and the outputs
    // expected just after that edge.
    typedef struct {
        logic btn;
        logic p;
        logic pr;
        logic rl;
        logic lg;
        int   c;
    } vec_t;

    localparam int NVEC = 117;
    vec_t tbl[NVEC];

    // Pack {pressed, press, release, long, count}.
    function automatic logic [11:0] ex(input logic p, input logic pr, input logic rl,
                                       input logic lg, input int c);
        return {p, pr, rl, lg, c[7:0]};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got pressed,press,release,long,count=%b,%b,%b,%b,%0d required %b,%b,%b,%b,%0d",
                     name, act[11], act[10], act[9], act[8], act[7:0],
                     exp[11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    // Compare both instances; the LONG_CYC=0 instance must match with long cleared.
    task automatic check_both(input string name, input logic [11:0] exp);
        check({name, " main"},   {pressed, press, rel, lng, cnt}, exp);
        check({name, " nolong"}, {pressed_n, press_n, rel_n, lng_n, cnt_n}, exp & 12'hEFF);
    endtask

    // Drive pin and reset on the falling edge, sample 1 ns after the rising edge.
    task automatic step(input logic r, input logic b, input logic [11:0] exp, input string name);
        @(negedge clk);
        rst_n = r;
        btn   = b;
        @(posedge clk);
        #1;
        check_both(name, exp);
    endtask

    // Clean press then clean release from IDLE, count going c -> c+1.
    task automatic press_release(input int c, input string name);
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b0, ex(i >= 6, i == 6, 1'b0, 1'b0, (i >= 6) ? c + 1 : c), {name, " press"});
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b1, ex(i < 6, 1'b0, i == 6, 1'b0, c + 1), {name, " release"});
    endtask

    task automatic fill(input int lo, input int hi, input logic b, input logic p, input int c);
        for (int i = lo; i <= hi; i++) begin
            tbl[i].btn = b;
            tbl[i].p   = p;
            tbl[i].pr  = 1'b0;
            tbl[i].rl  = 1'b0;
            tbl[i].lg  = 1'b0;
            tbl[i].c   = c;
        end
    endtask

    initial begin
        // ---- Vector table --------------------------------------------------
        // Clean press held 30 cycles: press 6 edges after first low sample,
        // long exactly once 10 cycles later, then a clean release.
        fill(0, 5, 1'b0, 1'b0, 0);
        fill(6, 29, 1'b0, 1'b1, 1);
        tbl[6].pr  = 1'b1;
        tbl[16].lg = 1'b1;
        fill(30, 35, 1'b1, 1'b1, 1);
        fill(36, 39, 1'b1, 1'b0, 1);
        tbl[36].rl = 1'b1;
        // Glitch: low for 3 cycles is rejected.
        fill(40, 42, 1'b0, 1'b0, 1);
        fill(43, 50, 1'b1, 1'b0, 1);
        // Press, then bouncy release 1,0,1,0,1...: one release 6 edges after the last 0->1.
        fill(51, 56, 1'b0, 1'b0, 1);
        fill(57, 58, 1'b0, 1'b1, 2);
        tbl[57].pr = 1'b1;
        fill(59, 68, 1'b1, 1'b1, 2);
        tbl[60].btn = 1'b0;
        tbl[62].btn = 1'b0;
        fill(69, 72, 1'b1, 1'b0, 2);
        tbl[69].rl = 1'b1;
        // Long press, one-cycle release bounce, long hold again: no second long.
        fill(73, 78, 1'b0, 1'b0, 2);
        fill(79, 108, 1'b0, 1'b1, 3);
        tbl[79].pr  = 1'b1;
        tbl[89].lg  = 1'b1;
        tbl[93].btn = 1'b1;
        fill(109, 114, 1'b1, 1'b1, 3);
        fill(115, 116, 1'b1, 1'b0, 3);
        tbl[115].rl = 1'b1;

        // ---- Reset with the pin toggling ----------------------------------
        #1;
        check_both("reset initial", 12'h000);
        for (int i = 0; i < 6; i++)
            step(1'b0, i[0], 12'h000, "reset toggling");

        // ---- Leave reset with pin released: nothing happens ----------------
        for (int i = 0; i < 20; i++)
            step(1'b1, 1'b1, 12'h000, "post-reset idle");

        // ---- Table ---------------------------------------------------------
        for (int i = 0; i < NVEC; i++)
            step(1'b1, tbl[i].btn, ex(tbl[i].p, tbl[i].pr, tbl[i].rl, tbl[i].lg, tbl[i].c),
                 $sformatf("vec[%0d]", i));

        // ---- Reset while HELD ----------------------------------------------
        for (int i = 0; i < 9; i++)
            step(1'b1, 1'b0, ex(i >= 6, i == 6, 1'b0, 1'b0, (i >= 6) ? 4 : 3), "pre-reset press");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_both("async reset in HELD", 12'h000);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 12'h000, "reset held button");
        // Button still held at release of reset: a fresh press after full latency.
        press_release(0, "held through reset");

        // ---- 256 presses wrap the count back to 0 --------------------------
        step(1'b0, 1'b1, 12'h000, "reset before wrap");
        step(1'b0, 1'b1, 12'h000, "reset before wrap");
        for (int n = 0; n < 256; n++)
            press_release(n, $sformatf("wrap press %0d", n));
        check("wrap final count", {4'h0, cnt}, 12'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
